// File: rtl/hyperbus_trans_arb_if.sv
// ============================================================================
// Module   : hyperbus_trans_arb_if
// Brief    : Transfer/TX/RX/B channel bundle, NUM_PORTS wide (1 for downstream)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hyperbus_trans_arb_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 16
) ();
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]                 trans_valid;
  logic [NUM_PORTS-1:0]                 trans_ready;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] trans_addr;
  logic [NUM_PORTS-1:0][LEN_WIDTH-1:0]  trans_len;
  logic [NUM_PORTS-1:0]                 trans_write;

  logic [NUM_PORTS-1:0]                 tx_valid;
  logic [NUM_PORTS-1:0]                 tx_ready;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] tx_data;
  logic [NUM_PORTS-1:0][STRB_W-1:0]     tx_strb;
  logic [NUM_PORTS-1:0]                 tx_last;

  // Read data and response status are shared; only valid/ready are per port.
  logic [NUM_PORTS-1:0]                 rx_valid;
  logic [NUM_PORTS-1:0]                 rx_ready;
  logic [DATA_WIDTH-1:0]                rx_data;
  logic                                 rx_last;
  logic                                 rx_error;

  logic [NUM_PORTS-1:0]                 b_valid;
  logic [NUM_PORTS-1:0]                 b_ready;
  logic                                 b_error;

  modport master (
    output trans_valid, trans_addr, trans_len, trans_write,
    output tx_valid, tx_data, tx_strb, tx_last,
    output rx_ready, b_ready,
    input  trans_ready, tx_ready,
    input  rx_valid, rx_data, rx_last, rx_error,
    input  b_valid, b_error
  );

  modport slave (
    input  trans_valid, trans_addr, trans_len, trans_write,
    input  tx_valid, tx_data, tx_strb, tx_last,
    input  rx_ready, b_ready,
    output trans_ready, tx_ready,
    output rx_valid, rx_data, rx_last, rx_error,
    output b_valid, b_error
  );
endinterface

`default_nettype wire

// File: rtl/hyperbus_trans_arb.sv
// ============================================================================
// Module   : hyperbus_trans_arb
// Brief    : N-port HyperBus transfer arbiter, grant locked until completion
// Revision : 1.0
// ============================================================================
`default_nettype none

module hyperbus_trans_arb #(
  parameter int  NUM_PORTS  = 2,
  parameter int  ADDR_WIDTH = 32,
  parameter int  LEN_WIDTH  = 8,
  parameter int  DATA_WIDTH = 16,
  parameter int  ARB_MODE   = 0,
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hyperbus_trans_arb_if.slave  up,
  hyperbus_trans_arb_if.master dn,
  output logic [PORT_W-1:0]    grant_idx_o,
  output logic                 busy_o,
  output logic                 len_err_o
);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WDATA = 3'd2,
    S_WRESP = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PORT_W-1:0]     r_rr_ptr;
  logic [PORT_W-1:0]     r_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_write;
  logic [LEN_WIDTH:0]    r_cnt;
  logic                  r_err_seen;

  logic                  w_found;
  logic [PORT_W-1:0]     w_win;
  logic [PORT_W-1:0]     w_idx;
  logic                  w_hs_tx;
  logic                  w_hs_rx;
  logic                  w_beat;
  logic                  w_last;
  logic [LEN_WIDTH:0]    w_len_ext;
  logic [LEN_WIDTH:0]    w_len_p1;
  logic                  w_len_err;
  logic [DATA_WIDTH-1:0] w_tx_data;
  logic [STRB_W-1:0]     w_tx_strb;

  // Fixed priority scans from port 0; round-robin scans from r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 1) w_idx = PORT_W'(i);
      else               w_idx = PORT_W'((int'(r_rr_ptr) + i) % NUM_PORTS);
      if (!w_found && up.trans_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_hs_tx   = (r_state == S_WDATA) && up.tx_valid[r_grant] && dn.tx_ready[0];
  assign w_hs_rx   = (r_state == S_RDATA) && dn.rx_valid[0] && up.rx_ready[r_grant];
  assign w_beat    = w_hs_tx || w_hs_rx;
  assign w_last    = (r_state == S_WDATA) ? up.tx_last[r_grant] : dn.rx_last;
  assign w_len_ext = {1'b0, r_len};
  assign w_len_p1  = w_len_ext + 1'b1;
  // At most one pulse per transfer: early last, or the first beat past len.
  assign w_len_err = w_beat && !r_err_seen &&
                     (w_last ? (r_cnt != w_len_ext) : (r_cnt == w_len_p1));
  assign w_tx_data = up.tx_data[r_grant];
  assign w_tx_strb = up.tx_strb[r_grant];

  assign len_err_o      = w_len_err;
  assign busy_o         = (r_state != S_IDLE);
  assign grant_idx_o    = r_grant;
  assign dn.trans_addr  = r_addr;
  assign dn.trans_len   = r_len;
  assign dn.trans_write = r_write;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    up.trans_ready = '0;
    up.tx_ready    = '0;
    up.rx_valid    = '0;
    up.b_valid     = '0;
    up.rx_data     = dn.rx_data;
    up.rx_last     = dn.rx_last;
    up.rx_error    = dn.rx_error;
    up.b_error     = dn.b_error;
    dn.trans_valid = 1'b0;
    dn.tx_valid    = 1'b0;
    dn.tx_data     = '0;
    dn.tx_strb     = '0;
    dn.tx_last     = 1'b0;
    dn.rx_ready    = 1'b0;
    dn.b_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !rst_i) begin
          up.trans_ready[w_win] = 1'b1;
          w_state_nxt           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dn.trans_valid = 1'b1;
        if (dn.trans_ready[0]) w_state_nxt = r_write ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        dn.tx_valid          = up.tx_valid[r_grant];
        dn.tx_data           = w_tx_data;
        dn.tx_strb           = w_tx_strb;
        dn.tx_last           = up.tx_last[r_grant];
        up.tx_ready[r_grant] = dn.tx_ready[0];
        if (w_hs_tx && up.tx_last[r_grant]) w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        up.b_valid[r_grant] = dn.b_valid[0];
        dn.b_ready          = up.b_ready[r_grant];
        if (dn.b_valid[0] && up.b_ready[r_grant]) w_state_nxt = S_IDLE;
      end
      S_RDATA: begin
        up.rx_valid[r_grant] = dn.rx_valid[0];
        dn.rx_ready          = up.rx_ready[r_grant];
        if (w_hs_rx && dn.rx_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_write    <= 1'b0;
      r_cnt      <= '0;
      r_err_seen <= 1'b0;
    end else if (r_state == S_IDLE && w_found) begin
      r_grant    <= w_win;
      r_addr     <= up.trans_addr[w_win];
      r_len      <= up.trans_len[w_win];
      r_write    <= up.trans_write[w_win];
      r_cnt      <= '0;
      r_err_seen <= 1'b0;
      if (ARB_MODE == 0)
        r_rr_ptr <= (w_win == PORT_W'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
    end else begin
      if (w_beat && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      if (w_len_err)               r_err_seen <= 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_hyperbus_trans_arb.sv
// ============================================================================
// Module   : tb_hyperbus_trans_arb
// Brief    : Randomized bench for hyperbus_trans_arb against a transfer-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hyperbus_trans_arb;
  localparam int NP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant, grant2;
  logic       busy, busy2, len_err, len_err2;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending requests, round-robin pointer, per-port request attributes.
  bit   [3:0]  m_req = '0;
  int          m_ptr = 0;
  bit          req_wr   [NP];
  int          req_len  [NP];
  int          req_nb   [NP];
  int          req_errk [NP];
  bit          req_berr [NP];
  logic [31:0] req_addr [NP];

  hyperbus_trans_arb_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .LEN_WIDTH(8), .DATA_WIDTH(16)) u_if ();
  hyperbus_trans_arb_if #(.NUM_PORTS(1),  .ADDR_WIDTH(32), .LEN_WIDTH(8), .DATA_WIDTH(16)) d_if ();
  hyperbus_trans_arb_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .LEN_WIDTH(8), .DATA_WIDTH(16)) u2_if ();
  hyperbus_trans_arb_if #(.NUM_PORTS(1),  .ADDR_WIDTH(32), .LEN_WIDTH(8), .DATA_WIDTH(16)) d2_if ();

  hyperbus_trans_arb #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .LEN_WIDTH(8), .DATA_WIDTH(16), .ARB_MODE(0)) dut (
    .clk_i(clk), .rst_i(rst), .up(u_if), .dn(d_if),
    .grant_idx_o(grant), .busy_o(busy), .len_err_o(len_err)
  );

  hyperbus_trans_arb #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .LEN_WIDTH(8), .DATA_WIDTH(16), .ARB_MODE(1)) dut_fp (
    .clk_i(clk), .rst_i(rst), .up(u2_if), .dn(d2_if),
    .grant_idx_o(grant2), .busy_o(busy2), .len_err_o(len_err2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    for (int i = 0; i < NP; i++)
      if (m_req[(m_ptr + i) % NP]) return (m_ptr + i) % NP;
    return -1;
  endfunction

  // Beat index (0-based) at which the single length-error pulse is due, -1 if none.
  function automatic int err_beat(input int len, input int nb);
    if (nb == len + 1) return -1;
    if (nb < len + 1)  return nb - 1;
    return len + 1;
  endfunction

  task automatic request(input int p, input bit wr, input int len, input int nb,
                         input int errk, input bit berr);
    m_req[p]    = 1'b1;
    req_wr[p]   = wr;
    req_len[p]  = len;
    req_nb[p]   = nb;
    req_errk[p] = errk;
    req_berr[p] = berr;
    req_addr[p] = $urandom;
    u_if.trans_valid[p] = 1'b1;
    u_if.trans_addr[p]  = req_addr[p];
    u_if.trans_len[p]   = 8'(len);
    u_if.trans_write[p] = wr;
  endtask

  // Grants the model's winner and plays both ends of its transfer.
  task automatic serve(input int abort_at);
    int p, k, eb, g;
    bit hs;
    p = model_pick();
    if (p < 0) return;
    @(negedge clk);
    check("grant_onehot", u_if.trans_ready, 64'(4'b0001 << p));
    check("busy_idle", busy, 0);
    @(posedge clk); #1;
    m_ptr = (p + 1) % NP;
    m_req[p] = 1'b0;
    u_if.trans_valid[p] = 1'b0;
    u_if.trans_addr[p]  = ~req_addr[p];
    u_if.trans_len[p]   = ~u_if.trans_len[p];
    u_if.trans_write[p] = ~req_wr[p];

    g = 0; hs = 0;
    while (!hs) begin
      d_if.trans_ready = (g >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("dn_trans_valid", d_if.trans_valid, 1);
      check("dn_trans_addr", d_if.trans_addr, req_addr[p]);
      check("dn_trans_len", d_if.trans_len, 64'(req_len[p]));
      check("dn_trans_write", d_if.trans_write, req_wr[p]);
      check("grant_idx", grant, 64'(p));
      check("busy_issue", busy, 1);
      check("no_trans_ready", u_if.trans_ready, 0);
      hs = d_if.trans_ready[0];
      @(posedge clk); #1;
      g++;
    end
    d_if.trans_ready = 1'b0;

    eb = err_beat(req_len[p], req_nb[p]);
    k = 0; g = 0;
    if (req_wr[p]) begin
      while (k < req_nb[p]) begin
        u_if.tx_valid[p] = (g % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        u_if.tx_data[p]  = 16'($urandom);
        u_if.tx_strb[p]  = 2'($urandom);
        u_if.tx_last[p]  = (k == req_nb[p] - 1);
        d_if.tx_ready    = (g % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        hs = u_if.tx_valid[p] && d_if.tx_ready[0];
        check("dn_tx_valid", d_if.tx_valid, u_if.tx_valid[p]);
        if (u_if.tx_valid[p]) begin
          check("dn_tx_data", d_if.tx_data, u_if.tx_data[p]);
          check("dn_tx_strb", d_if.tx_strb, u_if.tx_strb[p]);
          check("dn_tx_last", d_if.tx_last, u_if.tx_last[p]);
        end
        check("up_tx_ready", u_if.tx_ready, 64'({3'b000, d_if.tx_ready[0]} << p));
        check("wr_len_err", len_err, 64'(hs && (k == eb)));
        check("dn_trans_quiet", d_if.trans_valid, 0);
        @(posedge clk); #1;
        if (hs) k++;
        g++;
      end
      u_if.tx_valid[p] = 1'b0;
      u_if.tx_last[p]  = 1'b0;
      d_if.tx_ready    = 1'b0;
      g = 0; hs = 0;
      while (!hs) begin
        d_if.b_valid = (g % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        d_if.b_error = req_berr[p];
        u_if.b_ready = 4'($urandom);
        if (g % 4 == 3) u_if.b_ready[p] = 1'b1;
        @(negedge clk);
        hs = d_if.b_valid[0] && u_if.b_ready[p];
        check("up_b_valid", u_if.b_valid, 64'({3'b000, d_if.b_valid[0]} << p));
        if (d_if.b_valid[0]) check("up_b_error", u_if.b_error, req_berr[p]);
        check("dn_b_ready", d_if.b_ready, u_if.b_ready[p]);
        check("dn_tx_quiet", d_if.tx_valid, 0);
        @(posedge clk); #1;
        g++;
      end
      d_if.b_valid = 1'b0;
      u_if.b_ready = '0;
    end else begin
      while (k < req_nb[p]) begin
        if (k == abort_at) begin
          rst = 1'b1;
          d_if.rx_valid = 1'b1;
          u_if.rx_ready = '1;
          @(posedge clk);
          @(negedge clk);
          check("abort_busy", busy, 0);
          check("abort_grant", grant, 0);
          check("abort_rx_valid", u_if.rx_valid, 0);
          check("abort_rx_ready", d_if.rx_ready, 0);
          check("abort_trans_valid", d_if.trans_valid, 0);
          check("abort_trans_addr", d_if.trans_addr, 0);
          check("abort_len_err", len_err, 0);
          @(posedge clk); #1;
          rst = 1'b0;
          d_if.rx_valid = 1'b0;
          u_if.rx_ready = '0;
          m_ptr = 0;
          return;
        end
        d_if.rx_valid = (g % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        d_if.rx_data  = 16'($urandom);
        d_if.rx_last  = (k == req_nb[p] - 1);
        d_if.rx_error = (k == req_errk[p]);
        u_if.rx_ready = 4'($urandom);
        if (g % 4 == 3) u_if.rx_ready[p] = 1'b1;
        @(negedge clk);
        hs = d_if.rx_valid[0] && u_if.rx_ready[p];
        check("up_rx_valid", u_if.rx_valid, 64'({3'b000, d_if.rx_valid[0]} << p));
        if (d_if.rx_valid[0]) begin
          check("up_rx_data", u_if.rx_data, d_if.rx_data);
          check("up_rx_last", u_if.rx_last, d_if.rx_last);
          check("up_rx_error", u_if.rx_error, 64'(k == req_errk[p]));
        end
        check("dn_rx_ready", d_if.rx_ready, u_if.rx_ready[p]);
        check("rd_len_err", len_err, 64'(hs && (k == eb)));
        @(posedge clk); #1;
        if (hs) k++;
        g++;
      end
      d_if.rx_valid = 1'b0;
      d_if.rx_last  = 1'b0;
      d_if.rx_error = 1'b0;
      u_if.rx_ready = '0;
    end
  endtask

  initial begin
    int len, nb, ng;
    bit [3:0] mask;
    logic [3:0] fp_pat [4];
    logic [3:0] lo;

    u_if.trans_valid = '0; u_if.trans_addr = '0; u_if.trans_len = '0; u_if.trans_write = '0;
    u_if.tx_valid = '0; u_if.tx_data = '0; u_if.tx_strb = '0; u_if.tx_last = '0;
    u_if.rx_ready = '0; u_if.b_ready = '0;
    d_if.trans_ready = '0; d_if.tx_ready = '0;
    d_if.rx_valid = '0; d_if.rx_data = '0; d_if.rx_last = 1'b0; d_if.rx_error = 1'b0;
    d_if.b_valid = '0; d_if.b_error = 1'b0;
    u2_if.trans_valid = '0; u2_if.trans_addr = '0; u2_if.trans_len = '0; u2_if.trans_write = '0;
    u2_if.tx_valid = '0; u2_if.tx_data = '0; u2_if.tx_strb = '0; u2_if.tx_last = '0;
    u2_if.rx_ready = '1; u2_if.b_ready = '0;
    d2_if.trans_ready = '1; d2_if.tx_ready = '0;
    d2_if.rx_valid = '1; d2_if.rx_data = '0; d2_if.rx_last = 1'b1; d2_if.rx_error = 1'b0;
    d2_if.b_valid = '0; d2_if.b_error = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_len_err", len_err, 0);
    check("rst_trans_valid", d_if.trans_valid, 0);
    check("rst_trans_addr", d_if.trans_addr, 0);
    check("rst_trans_len", d_if.trans_len, 0);
    check("rst_trans_write", d_if.trans_write, 0);
    check("rst_trans_ready", u_if.trans_ready, 0);
    check("rst_tx", {u_if.tx_ready, d_if.tx_valid}, 0);
    check("rst_rx", {u_if.rx_valid, d_if.rx_ready}, 0);
    check("rst_b", {u_if.b_valid, d_if.b_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write, exact length.
    request(0, 1'b1, 3, 4, 0, 1'b0);
    serve(-1);

    // Round-robin across three simultaneously requesting ports, two rounds.
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < 3; q++) request(q, 1'($urandom_range(0, 1)), 0, 1, 1, 1'($urandom_range(0, 1)));
      for (int q = 0; q < 3; q++) serve(-1);
    end

    // Long read with error on beat 5; then short and long writes.
    request(3, 1'b0, 7, 8, 4, 1'b0);
    serve(-1);
    request(1, 1'b1, 3, 2, 0, 1'b1);
    serve(-1);
    request(1, 1'b1, 1, 4, 0, 1'b0);
    serve(-1);

    for (int it = 0; it < 12; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int q = 0; q < NP; q++) begin
        if (mask[q]) begin
          len = $urandom_range(0, 5);
          nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 3) : len + 1;
          request(q, 1'($urandom_range(0, 1)), len, nb, $urandom_range(0, nb), 1'($urandom_range(0, 1)));
        end
      end
      while (model_pick() >= 0) serve(-1);
    end

    // Reset during a read, then all ports request: port 0 must win first.
    request(2, 1'b0, 7, 8, 8, 1'b0);
    serve(3);
    m_req = '0;
    for (int q = 0; q < NP; q++) request(q, 1'b0, 0, 1, 1, 1'b0);
    for (int q = 0; q < NP; q++) serve(-1);
    @(negedge clk);
    check("final_busy", busy, 0);
    @(posedge clk); #1;

    // Fixed priority: downstream always ready, each transfer takes three cycles.
    fp_pat[0] = 4'b1010; fp_pat[1] = 4'b1000; fp_pat[2] = 4'b1011; fp_pat[3] = 4'b0110;
    for (int s = 0; s < 4; s++) begin
      u2_if.trans_valid = fp_pat[s];
      lo = fp_pat[s] & (~fp_pat[s] + 4'd1);
      ng = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (u2_if.trans_ready != 4'd0) begin
          check("fp_grant", u2_if.trans_ready, lo);
          ng++;
        end
        @(posedge clk); #1;
      end
      check("fp_grant_count", ng, 2);
    end
    u2_if.trans_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/hyperbus_trans_arb.md
# hyperbus_trans_arb

Multi-port transfer arbiter for the HyperBus controller, in the system clock domain between N upstream transfer generators (AXI slaves, DMA, debug) and the single transfer/TX/RX/B channel set feeding the PHY-side CDCs. It grants one port at a time, locks the grant until that transfer fully completes, and routes write data, read data and write responses to and from the granted port. It supersedes the fixed single-slave hookup with a parametrised port count, a selectable arbitration mode and beat-count checking.

## Interface

- NumPorts, 2: upstream ports, ≥1; PortW = max(1, $clog2(NumPorts)).
- AddrWidth, 32: transfer address width.
- LenWidth, 8: burst length field (beats − 1).
- DataWidth, 16: TX/RX data width; StrbW = DataWidth/8.
- ArbMode, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- clk_i in 1: system clock.
- rst_i in 1: reset, synchronous, active-high.
- up_trans_valid_i / up_trans_ready_o in/out NumPorts: per-port transfer handshake.
- up_trans_addr_i in NumPorts×AddrWidth; up_trans_len_i in NumPorts×LenWidth; up_trans_write_i in NumPorts.
- up_tx_valid_i / up_tx_ready_o in/out NumPorts; up_tx_data_i in NumPorts×DataWidth; up_tx_strb_i in NumPorts×StrbW; up_tx_last_i in NumPorts.
- up_rx_valid_o / up_rx_ready_i out/in NumPorts; up_rx_data_o out DataWidth (shared); up_rx_last_o out 1; up_rx_error_o out 1.
- up_b_valid_o / up_b_ready_i out/in NumPorts; up_b_error_o out 1 (shared).
- dn_trans_valid_o / dn_trans_ready_i out/in 1; dn_trans_addr_o, dn_trans_len_o, dn_trans_write_o out: registered copy of granted request.
- dn_tx_valid_o / dn_tx_ready_i, dn_tx_data_o, dn_tx_strb_o, dn_tx_last_o: downstream write data.
- dn_rx_valid_i / dn_rx_ready_o, dn_rx_data_i, dn_rx_last_i, dn_rx_error_i: downstream read data.
- dn_b_valid_i / dn_b_ready_o, dn_b_error_i: downstream write response.
- grant_idx_o out PortW: current/last granted port.
- busy_o out 1: state ≠ IDLE.
- len_err_o out 1: one-cycle pulse on beat-count mismatch.

## Operation

- States: IDLE, ISSUE, WDATA, WRESP, RDATA.
- IDLE: if any up_trans_valid_i, pick winner; assert up_trans_ready_o[winner] only (combinational, this cycle); capture addr/len/write, grant_idx, beat counter := 0; → ISSUE. No other up_trans_ready_o ever high.
- Round-robin: search starts at rr_ptr; after grant rr_ptr := winner+1 mod NumPorts. Fixed priority: rr_ptr unused.
- ISSUE: dn_trans_valid_o = 1, fields stable; on dn_trans_ready_i → WDATA (write) or RDATA (read).
- WDATA: connect granted up_tx to dn_tx; other up_tx_ready_o = 0. Count handshaken beats. On handshake with last: if count ≠ len → len_err_o pulse; → WRESP. Beat count reaching len+1 without last: pulse len_err_o once, keep forwarding until last.
- WRESP: route dn_b to granted port's up_b; on handshake → IDLE.
- RDATA: route dn_rx to granted port's up_rx; up_rx_valid_o high only at grant index. Count beats; on handshake with dn_rx_last_i: mismatch → len_err_o; → IDLE. error bit passed through unchanged.
- Non-granted ports: all valid/ready outputs 0. dn_*_ready_o = 0 outside their phase (dn_tx_valid_o=0 outside WDATA, etc.).
- Beat counter width LenWidth+1; saturates, no wrap.

## Timing

- Reset: state IDLE, rr_ptr 0, grant_idx_o 0, all valid/ready outputs 0, busy_o 0, len_err_o 0, dn_trans fields 0.
- Request to dn_trans_valid_o: 1 cycle (upstream accepted in IDLE, valid next cycle).
- Data paths (tx, rx, b) are combinational pass-through in their state: 0 cycles, ready/valid mirror.
- Completion to next grant: last beat/B handshake in cycle t → IDLE at t+1 → new up_trans_ready_o at t+1 → dn_trans_valid_o at t+2.
- dn_trans_valid_o once high stays high with stable fields until accepted.
- Reset asserted mid-transfer: all outputs to reset values next edge; in-flight transfer abandoned, no B/RX emitted.
- Request dropped before grant: legal only in IDLE unchosen ports; granted requests are captured, later valid changes ignored.

## Test plan

- Single port 0 write len=3, 4 TX beats last on 4th, B error=0 → dn_trans at +1 cycle, 4 dn_tx beats, up_b_valid_o[0]=1 error 0, busy_o drops, len_err_o never.
- Ports 0,1,2 (NumPorts=4, ArbMode=0) request simultaneously, repeat 2 rounds → grant order 0,1,2,0,1,2; no overlap of transfers.
- ArbMode=1, ports 1 and 3 continuously requesting → port 1 always granted, port 3 only when port 1 idle.
- Read len=7 with dn_rx_ready back-pressure via up_rx_ready_i toggling, error on beat 5 → 8 beats to granted port only, error passed on beat 5, other ports' up_rx_valid_o=0.
- Write len=3 with last on beat 2 → len_err_o one pulse, WRESP entered; and len=1 with last on beat 4 → one pulse at beat 3.
- Reset during RDATA beat 3 → next cycle all outputs reset, grant restarts at port 0.
